// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory read port, redirect input and decode-side output.
// The fetch unit uses the master modport. The memory/decode/redirect side uses the slave modport.
interface instr_fetch_unit_if #(
    parameter int XLEN     = 32,
    parameter int ADDR_W   = 8,
    parameter int FQ_DEPTH = 4
);
    localparam int CNT_W = $clog2(FQ_DEPTH + 1);

    // Handshake: decode takes {out_instr, out_pc} on a rising edge where out_valid & out_ready.
    // out_valid never depends on out_ready. imem_rdata answers imem_req on the following cycle.
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [XLEN-1:0]   imem_rdata;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_instr;
    logic [XLEN-1:0]   out_pc;
    logic [CNT_W-1:0]  fq_count;

    modport master (
        output imem_req, imem_addr, out_valid, out_instr, out_pc, fq_count,
        input  imem_rdata, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_instr, out_pc, fq_count,
        output imem_rdata, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, reads a synchronous instruction memory and queues {instr, pc}
// in a small fetch queue for decode. A redirect flushes the queue and the in-flight read.
module instr_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              ADDR_W   = 8,
    parameter int              FQ_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    instr_fetch_unit_if.master  bus
);
    localparam int PTR_W = $clog2(FQ_DEPTH);
    localparam int CNT_W = $clog2(FQ_DEPTH + 1);

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic             inflight_q, inflight_d;
    logic [XLEN-1:0]  inflight_pc_q, inflight_pc_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [XLEN-1:0]  fq_instr_q [FQ_DEPTH];
    logic [XLEN-1:0]  fq_pc_q    [FQ_DEPTH];

    logic [CNT_W:0]   occupancy;
    logic             issue;
    logic             enq;
    logic             head_valid;
    logic             deq;

    // Credit counts queued plus in-flight entries, so a response always finds a free slot.
    always_comb begin
        occupancy  = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
        issue      = ~reset & ~bus.redirect_valid & (occupancy < (CNT_W + 1)'(FQ_DEPTH));
        enq        = inflight_q & ~bus.redirect_valid;
        head_valid = (count_q != '0) & ~bus.redirect_valid;
        deq        = head_valid & bus.out_ready;
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = fetch_pc_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        if (bus.redirect_valid) begin
            fetch_pc_d = bus.redirect_pc;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (issue) fetch_pc_d = fetch_pc_q + XLEN'(1);
            if (enq)   wr_ptr_d   = wr_ptr_q + PTR_W'(1);
            if (deq)   rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    // Queue storage needs no reset: nothing is visible until count_q says the slot is filled.
    always_ff @(posedge clk) begin
        if (enq) begin
            fq_instr_q[wr_ptr_q] <= bus.imem_rdata;
            fq_pc_q[wr_ptr_q]    <= inflight_pc_q;
        end
    end

    assign bus.imem_req  = issue;
    assign bus.imem_addr = fetch_pc_q[ADDR_W-1:0];
    assign bus.out_valid = head_valid;
    assign bus.out_instr = head_valid ? fq_instr_q[rd_ptr_q] : '0;
    assign bus.out_pc    = head_valid ? fq_pc_q[rd_ptr_q] : '0;
    assign bus.fq_count  = count_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: scoreboard of golden {pc, instr} plus scenario tasks.
module tb_instr_fetch_unit;
    localparam int XLEN     = 32;
    localparam int ADDR_W   = 8;
    localparam int FQ_DEPTH = 4;

    logic clk     = 1'b0;
    logic reset   = 1'b1;
    logic reset_b = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_deq    = 0;
    logic [2*XLEN-1:0] exp_q[$];
    logic [XLEN-1:0]   imem [256];

    instr_fetch_unit_if #(.XLEN(XLEN), .ADDR_W(ADDR_W), .FQ_DEPTH(FQ_DEPTH)) u_if ();
    instr_fetch_unit_if #(.XLEN(XLEN), .ADDR_W(ADDR_W), .FQ_DEPTH(FQ_DEPTH)) u_if_b ();

    instr_fetch_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W), .FQ_DEPTH(FQ_DEPTH), .RESET_PC(32'd0)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.master)
    );

    instr_fetch_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W), .FQ_DEPTH(FQ_DEPTH), .RESET_PC(32'd254)) u_dut_b (
        .clk   (clk),
        .reset (reset_b),
        .bus   (u_if_b.master)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Synchronous instruction memories, one read port per DUT
    always @(posedge clk) begin
        if (u_if.imem_req)   u_if.imem_rdata   <= imem[u_if.imem_addr];
        if (u_if_b.imem_req) u_if_b.imem_rdata <= imem[u_if_b.imem_addr];
    end

    // Scoreboard: every accepted head must match the next golden {pc, instr}
    always @(negedge clk) begin
        logic [2*XLEN-1:0] exp;
        if (!reset && u_if.out_valid && u_if.out_ready) begin
            n_deq++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_underflow: got pc=%h instr=%h, expected nothing", u_if.out_pc, u_if.out_instr);
            end else begin
                exp = exp_q.pop_front();
                if ({u_if.out_pc, u_if.out_instr} !== exp) begin
                    n_fail++;
                    $display("FAIL sb_data: got pc=%h instr=%h, expected pc=%h instr=%h",
                             u_if.out_pc, u_if.out_instr, exp[63:32], exp[31:0]);
                end
            end
        end
    end

    // Golden PC model: contiguous PCs from a restart point, instr = imem at the wrapped address
    task automatic push_run(input logic [XLEN-1:0] start_pc, input int n);
        logic [XLEN-1:0] pc;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            pc = start_pc + XLEN'(i);
            exp_q.push_back({pc, 32'h1000 + {24'd0, pc[7:0]}});
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (u_if.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", u_if.imem_req); end
        n_checks++;
        if (u_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", u_if.out_valid); end
        n_checks++;
        if ({u_if.out_instr, u_if.out_pc} !== 64'd0) begin
            n_fail++; $display("FAIL reset_data: got instr=%h pc=%h expected 0", u_if.out_instr, u_if.out_pc);
        end
        n_checks++;
        if (u_if.fq_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", u_if.fq_count); end
    endtask

    task automatic test_stream();
        @(posedge clk);
        #1;
        reset = 1'b0;
        u_if.out_ready = 1'b1;
        push_run(32'd0, 200);
        @(negedge clk);
        n_checks++;
        if (u_if.imem_req !== 1'b1 || u_if.imem_addr !== 8'd0) begin
            n_fail++; $display("FAIL stream_first_req: got req=%b addr=%0d expected req=1 addr=0", u_if.imem_req, u_if.imem_addr);
        end
        n_checks++;
        if (u_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_c0_valid: got %b expected 0", u_if.out_valid); end
        @(negedge clk);
        n_checks++;
        if (u_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_c1_valid: got %b expected 0", u_if.out_valid); end
        @(negedge clk);
        n_checks++;
        if (u_if.out_valid !== 1'b1 || u_if.out_pc !== 32'd0) begin
            n_fail++; $display("FAIL stream_c2: got valid=%b pc=%h expected valid=1 pc=0", u_if.out_valid, u_if.out_pc);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++;
            if (u_if.out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_throughput: cycle %0d got valid=%b expected 1", i, u_if.out_valid); end
        end
    endtask

    task automatic test_backpressure();
        @(posedge clk);
        #1;
        u_if.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (u_if.fq_count > 3'd4) begin n_fail++; $display("FAIL bp_bound: got count=%0d expected <=4", u_if.fq_count); end
        end
        n_checks++;
        if (u_if.fq_count !== 3'd4 || u_if.imem_req !== 1'b0) begin
            n_fail++; $display("FAIL bp_full: got count=%0d req=%b expected count=4 req=0", u_if.fq_count, u_if.imem_req);
        end
        @(posedge clk);
        #1;
        u_if.out_ready = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_redirect_full();
        bit found = 1'b0;
        @(posedge clk);
        #1;
        u_if.out_ready = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (u_if.fq_count == 3'd3) found = 1'b1;
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL redir_setup: got count=%0d expected 3 within 20 cycles", u_if.fq_count); end
        #1;
        u_if.redirect_valid = 1'b1;
        u_if.redirect_pc    = 32'h40;
        push_run(32'h40, 100);
        #1;
        n_checks++;
        if (u_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_n_valid: got %b expected 0", u_if.out_valid); end
        @(posedge clk);
        #1;
        u_if.redirect_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (u_if.out_valid !== 1'b0 || u_if.imem_req !== 1'b1 || u_if.imem_addr !== 8'h40) begin
            n_fail++; $display("FAIL redir_n1: got valid=%b req=%b addr=%h expected valid=0 req=1 addr=40",
                               u_if.out_valid, u_if.imem_req, u_if.imem_addr);
        end
        @(negedge clk);
        n_checks++;
        if (u_if.out_valid !== 1'b0 || u_if.fq_count !== 3'd0) begin
            n_fail++; $display("FAIL redir_n2: got valid=%b count=%0d expected valid=0 count=0", u_if.out_valid, u_if.fq_count);
        end
        @(negedge clk);
        n_checks++;
        if (u_if.out_valid !== 1'b1 || u_if.out_pc !== 32'h40 || u_if.out_instr !== 32'h1040) begin
            n_fail++; $display("FAIL redir_n3: got valid=%b pc=%h instr=%h expected valid=1 pc=40 instr=1040",
                               u_if.out_valid, u_if.out_pc, u_if.out_instr);
        end
        @(posedge clk);
        #1;
        u_if.out_ready = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_redirect_vs_dequeue();
        int deq_before;
        @(posedge clk);
        #1;
        u_if.redirect_valid = 1'b1;
        u_if.redirect_pc    = 32'h80;
        push_run(32'h80, 100);
        deq_before = n_deq;
        @(negedge clk);
        n_checks++;
        if (u_if.out_valid !== 1'b0 || u_if.fq_count === 3'd0) begin
            n_fail++; $display("FAIL rvd_same_cycle: got valid=%b count=%0d expected valid=0 count!=0", u_if.out_valid, u_if.fq_count);
        end
        @(posedge clk);
        #1;
        u_if.redirect_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (u_if.fq_count !== 3'd0 || n_deq !== deq_before) begin
            n_fail++; $display("FAIL rvd_next: got count=%0d deqs=%0d expected count=0 deqs=%0d", u_if.fq_count, n_deq, deq_before);
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_pc_wrap();
        logic [7:0]  ea;
        logic [31:0] ep;
        @(posedge clk);
        #1;
        reset_b = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c < 4) begin
                ea = 8'd254 + 8'(c);
                n_checks++;
                if (u_if_b.imem_req !== 1'b1 || u_if_b.imem_addr !== ea) begin
                    n_fail++; $display("FAIL wrap_addr: cycle %0d got req=%b addr=%0d expected req=1 addr=%0d", c, u_if_b.imem_req, u_if_b.imem_addr, ea);
                end
            end
            if (c >= 2) begin
                ep = 32'd254 + 32'(c) - 32'd2;
                n_checks++;
                if (u_if_b.out_valid !== 1'b1 || u_if_b.out_pc !== ep || u_if_b.out_instr !== (32'h1000 + {24'd0, ep[7:0]})) begin
                    n_fail++; $display("FAIL wrap_out: cycle %0d got valid=%b pc=%0d instr=%h expected valid=1 pc=%0d instr=%h",
                                       c, u_if_b.out_valid, u_if_b.out_pc, u_if_b.out_instr, ep, 32'h1000 + {24'd0, ep[7:0]});
                end
            end
        end
    endtask

    task automatic test_async_reset();
        bit found = 1'b0;
        @(posedge clk);
        #1;
        u_if.out_ready = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (u_if.fq_count == 3'd3) found = 1'b1;
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL areset_setup: got count=%0d expected 3 within 20 cycles", u_if.fq_count); end
        #2;
        reset = 1'b1;
        exp_q.delete();
        #1;
        n_checks++;
        if (u_if.imem_req !== 1'b0 || u_if.out_valid !== 1'b0 || u_if.out_instr !== 32'd0 ||
            u_if.out_pc !== 32'd0 || u_if.fq_count !== 3'd0) begin
            n_fail++; $display("FAIL areset_immediate: got req=%b valid=%b instr=%h pc=%h count=%0d expected all 0",
                               u_if.imem_req, u_if.out_valid, u_if.out_instr, u_if.out_pc, u_if.fq_count);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        u_if.out_ready = 1'b1;
        push_run(32'd0, 100);
        @(negedge clk);
        n_checks++;
        if (u_if.imem_req !== 1'b1 || u_if.imem_addr !== 8'd0) begin
            n_fail++; $display("FAIL areset_restart: got req=%b addr=%0d expected req=1 addr=0", u_if.imem_req, u_if.imem_addr);
        end
        repeat (10) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 32'h1000 + 32'(i);
        u_if.redirect_valid   = 1'b0;
        u_if.redirect_pc      = '0;
        u_if.out_ready        = 1'b0;
        u_if_b.redirect_valid = 1'b0;
        u_if_b.redirect_pc    = '0;
        u_if_b.out_ready      = 1'b1;

        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_full();
        test_redirect_vs_dequeue();
        test_pc_wrap();
        test_async_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
